otter_mmio_bridge: RTL and testbench

Parametrised memory-mapped IO bridge between the OTTER MCU IOBUS and board peripherals. It replaces hand-written per-device address decode with generic slots:
- N_IN synchronised input ports
- N_OUT registered output ports with write strobes
- an edge-triggered, maskable interrupt controller producing INTR
- a buffered UART transmit channel (FIFO plus start/ready handshake)

It sits in the top-level wrapper on the CPU clock, between the MCU IOBUS and the peripherals.

---
 rtl/otter_mmio_bridge.sv | 228 ++++++++++++++++++++++
 tb/tb_otter_mmio_bridge.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_mmio_bridge.sv
// Generic IOBUS slot bridge for the OTTER MCU: synchronised inputs, strobed outputs,
// edge-triggered maskable interrupts and a FIFO-buffered UART transmit channel.

module otter_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

module otter_out_lane #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             stb
);
    // Strobe follows every write, even when the value does not change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q   <= '0;
            stb <= 1'b0;
        end else begin
            stb <= we;
            if (we) q <= d;
        end
    end
endmodule

module otter_mmio_bridge #(
    parameter int          N_IN       = 2,
    parameter int          N_OUT      = 2,
    parameter int          W          = 16,
    parameter int          N_IRQ      = 2,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_AD    = 32'h11000000,
    parameter logic [31:0] STRIDE     = 32'h00040000
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [31:0]          IOBUS_ADDR,
    input  logic [31:0]          IOBUS_OUT,
    input  logic                 IOBUS_WR,
    output logic [31:0]          IOBUS_IN,
    input  logic [N_IN*W-1:0]    IN_PORTS,
    output logic [N_OUT*W-1:0]   OUT_PORTS,
    output logic [N_OUT-1:0]     OUT_STB,
    input  logic [N_IRQ-1:0]     IRQ_SRC,
    output logic                 INTR,
    output logic [7:0]           TX_DATA,
    output logic                 TX_START,
    input  logic                 TX_READY
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [31:0] A_IRQ_STAT = BASE_AD + STRIDE * 32'(N_IN + N_OUT);
    localparam logic [31:0] A_IRQ_MASK = BASE_AD + STRIDE * 32'(N_IN + N_OUT + 1);
    localparam logic [31:0] A_TX_DATA  = BASE_AD + STRIDE * 32'(N_IN + N_OUT + 2);
    localparam logic [31:0] A_TX_STAT  = BASE_AD + STRIDE * 32'(N_IN + N_OUT + 3);

    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} tx_state_t;

    logic [N_IN-1:0][W-1:0]  in_q;
    logic [N_IN-1:0]         in_hit;
    logic [N_OUT-1:0][W-1:0] out_q;
    logic [N_OUT-1:0]        out_hit;

    logic                    wr_irq_stat, wr_irq_mask, wr_tx_stat;
    logic [N_IRQ-1:0]        irq_s, irq_prev, pending, mask, irq_clr;

    logic [7:0]              mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [AW:0]             count;
    logic                    full, empty, push_req, push, pop, overflow;
    tx_state_t               state, state_nxt;
    logic [31:0]             rd_data;
    logic                    unused_bits;

    // ---------------- slot decode, input sync, output lanes ----------------
    genvar i;
    generate
        for (i = 0; i < N_IN; i++) begin : g_in
            localparam logic [31:0] ADDR = BASE_AD + STRIDE * 32'(i);
            assign in_hit[i] = (IOBUS_ADDR == ADDR);
            otter_sync #(.WIDTH(W)) u_sync (
                .clk (CLK),
                .rst (RESET),
                .d   (IN_PORTS[i*W +: W]),
                .q   (in_q[i])
            );
        end
        for (i = 0; i < N_OUT; i++) begin : g_out
            localparam logic [31:0] ADDR = BASE_AD + STRIDE * 32'(N_IN + i);
            assign out_hit[i] = (IOBUS_ADDR == ADDR);
            otter_out_lane #(.WIDTH(W)) u_lane (
                .clk (CLK),
                .rst (RESET),
                .we  (IOBUS_WR && out_hit[i]),
                .d   (IOBUS_OUT[W-1:0]),
                .q   (out_q[i]),
                .stb (OUT_STB[i])
            );
        end
    endgenerate

    assign OUT_PORTS   = out_q;
    assign wr_irq_stat = IOBUS_WR && (IOBUS_ADDR == A_IRQ_STAT);
    assign wr_irq_mask = IOBUS_WR && (IOBUS_ADDR == A_IRQ_MASK);
    assign wr_tx_stat  = IOBUS_WR && (IOBUS_ADDR == A_TX_STAT);
    assign push_req    = IOBUS_WR && (IOBUS_ADDR == A_TX_DATA);
    assign unused_bits = ^IOBUS_OUT;

    // ---------------- interrupts ----------------
    otter_sync #(.WIDTH(N_IRQ)) u_irq_sync (
        .clk (CLK),
        .rst (RESET),
        .d   (IRQ_SRC),
        .q   (irq_s)
    );

    assign irq_clr = wr_irq_stat ? IOBUS_OUT[N_IRQ-1:0] : '0;

    // A new edge is ORed in after the W1C mask so a simultaneous set survives.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            irq_prev <= '0;
            pending  <= '0;
            mask     <= '0;
            INTR     <= 1'b0;
        end else begin
            irq_prev <= irq_s;
            pending  <= (pending & ~irq_clr) | (irq_s & ~irq_prev);
            if (wr_irq_mask) mask <= IOBUS_OUT[N_IRQ-1:0];
            INTR     <= |(pending & mask);
        end
    end

    // ---------------- TX FIFO ----------------
    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign push  = push_req && !full;

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= IOBUS_OUT[7:0];
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            TX_DATA  <= 8'h00;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr  <= rd_ptr + AW'(1);
                TX_DATA <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (push_req && full)
                overflow <= 1'b1;
            else if (wr_tx_stat && IOBUS_OUT[2])
                overflow <= 1'b0;
        end
    end

    // ---------------- TX handshake FSM ----------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && TX_READY) begin
                    pop       = 1'b1;
                    state_nxt = START;
                end
            end
            START:     state_nxt = WAIT_BUSY;
            WAIT_BUSY: if (!TX_READY) state_nxt = WAIT_DONE;
            WAIT_DONE: if (TX_READY)  state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    assign TX_START = (state == START);

    // ---------------- read mux ----------------
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < N_IN; k++)
            if (in_hit[k]) rd_data = 32'(in_q[k]);
        for (int k = 0; k < N_OUT; k++)
            if (out_hit[k]) rd_data = 32'(out_q[k]);
        if (IOBUS_ADDR == A_IRQ_STAT) rd_data = 32'(pending);
        if (IOBUS_ADDR == A_IRQ_MASK) rd_data = 32'(mask);
        if (IOBUS_ADDR == A_TX_STAT)
            rd_data = {16'h0000, 8'(count), 5'b00000, overflow, full, empty};
    end

    assign IOBUS_IN = rd_data;

endmodule

// File: tb/tb_otter_mmio_bridge.sv
// Scoreboard bench for otter_mmio_bridge: directed stimulus queues expectations,
// one monitor process pops them whenever a check, an OUT_STB or a TX_START appears.

module tb_otter_mmio_bridge;
    localparam logic [31:0] A_IN0   = 32'h11000000;
    localparam logic [31:0] A_IN1   = 32'h11040000;
    localparam logic [31:0] A_OUT0  = 32'h11080000;
    localparam logic [31:0] A_OUT1  = 32'h110C0000;
    localparam logic [31:0] A_ISTAT = 32'h11100000;
    localparam logic [31:0] A_IMASK = 32'h11140000;
    localparam logic [31:0] A_TXD   = 32'h11180000;
    localparam logic [31:0] A_TXS   = 32'h111C0000;
    localparam logic [31:0] A_NONE  = 32'h11240000;
    localparam int K_RD = 0, K_INTR = 1, K_OUTS = 2;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] IOBUS_ADDR, IOBUS_OUT, IOBUS_IN;
    logic        IOBUS_WR;
    logic [31:0] IN_PORTS;
    logic [31:0] OUT_PORTS;
    logic [1:0]  OUT_STB;
    logic [1:0]  IRQ_SRC;
    logic        INTR;
    logic [7:0]  TX_DATA;
    logic        TX_START, TX_READY;

    logic stim_ready, uart_ready, uart_en, chk, done;

    typedef struct {
        string       name;
        int          kind;
        logic [63:0] expv;
    } chk_t;

    chk_t        chk_q[$];
    logic [63:0] stb_q[$];
    logic [7:0]  tx_q[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;

    always #5 CLK = ~CLK;
    assign TX_READY = uart_en ? uart_ready : stim_ready;

    otter_mmio_bridge dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .IOBUS_ADDR (IOBUS_ADDR),
        .IOBUS_OUT  (IOBUS_OUT),
        .IOBUS_WR   (IOBUS_WR),
        .IOBUS_IN   (IOBUS_IN),
        .IN_PORTS   (IN_PORTS),
        .OUT_PORTS  (OUT_PORTS),
        .OUT_STB    (OUT_STB),
        .IRQ_SRC    (IRQ_SRC),
        .INTR       (INTR),
        .TX_DATA    (TX_DATA),
        .TX_START   (TX_START),
        .TX_READY   (TX_READY)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Sampled by the monitor on the negedge of the current cycle; costs one cycle.
    task automatic check(input string name, input int kind, input logic [63:0] expv);
        chk_t c;
        c.name = name;
        c.kind = kind;
        c.expv = expv;
        chk_q.push_back(c);
        chk = 1'b1;
        @(negedge CLK);
        #1 chk = 1'b0;
        tick();
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] expv);
        IOBUS_ADDR = a;
        check(name, K_RD, 64'(expv));
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        IOBUS_ADDR = a;
        IOBUS_OUT  = d;
        IOBUS_WR   = 1'b1;
        tick();
        IOBUS_WR   = 1'b0;
    endtask

    task automatic pulse_irq(input int n);
        IRQ_SRC[n] = 1'b1;
        repeat (4) tick();
        IRQ_SRC[n] = 1'b0;
        tick();
    endtask

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // UART model: drops ready for 10 cycles after each start pulse.
    initial begin
        uart_ready = 1'b1;
        forever begin
            @(negedge CLK);
            if (uart_en && TX_START) begin
                tick();
                uart_ready = 1'b0;
                repeat (10) tick();
                uart_ready = 1'b1;
            end
        end
    end

    initial begin : monitor
        chk_t        c;
        logic [63:0] act, e;
        logic [7:0]  t;
        forever begin
            @(negedge CLK);
            cyc++;
            if (chk) begin
                if (chk_q.size() == 0) compare("chk_queue", 64'd1, 64'd0);
                else begin
                    c = chk_q.pop_front();
                    case (c.kind)
                        K_RD:    act = 64'(IOBUS_IN);
                        K_INTR:  act = 64'(INTR);
                        default: act = 64'({OUT_PORTS, OUT_STB, INTR, TX_START, TX_DATA});
                    endcase
                    compare(c.name, act, c.expv);
                end
            end
            if (|OUT_STB) begin
                if (stb_q.size() == 0) compare("unexpected_out_stb", 64'(OUT_STB), 64'd0);
                else begin
                    e = stb_q.pop_front();
                    compare("out_stb", 64'({OUT_STB, OUT_PORTS}), e);
                end
            end
            if (TX_START) begin
                if (tx_q.size() == 0) compare("unexpected_tx_start", 64'(TX_DATA), 64'h100);
                else begin
                    t = tx_q.pop_front();
                    compare("tx_byte", 64'(TX_DATA), 64'(t));
                end
            end
            if (done || cyc > 3000) begin
                if (!done) compare("timeout", 64'(cyc), 64'd3000);
                compare("stb_left", 64'(stb_q.size()), 64'd0);
                compare("tx_left", 64'(tx_q.size()), 64'd0);
                compare("chk_left", 64'(chk_q.size()), 64'd0);
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

    initial begin
        RESET = 1'b0; IOBUS_ADDR = '0; IOBUS_OUT = '0; IOBUS_WR = 1'b0;
        IN_PORTS = 32'h000000C3; IRQ_SRC = '0;
        stim_ready = 1'b0; uart_en = 1'b0; chk = 1'b0; done = 1'b0;
        #2 RESET = 1'b1;
        repeat (3) tick();
        check("reset_outs", K_OUTS, 64'd0);
        rd("reset_txstat", A_TXS, 32'h1);
        RESET = 1'b0;
        tick();

        // output slots, unmapped and TX_DATA reads
        stb_q.push_back(64'({2'b01, 32'h0000BEEF}));
        wr(A_OUT0, 32'h0000BEEF);
        stb_q.push_back(64'({2'b10, 32'hA5A5BEEF}));
        wr(A_OUT1, 32'hFFFFA5A5);
        stb_q.push_back(64'({2'b01, 32'hA5A5BEEF}));
        wr(A_OUT0, 32'h0000BEEF);
        rd("out0_rd", A_OUT0, 32'h0000BEEF);
        rd("out1_rd", A_OUT1, 32'h0000A5A5);
        rd("unmapped_rd", A_NONE, 32'h0);
        rd("txdata_rd", A_TXD, 32'h0);

        // input synchronisation
        rd("in0_rd", A_IN0, 32'h000000C3);
        wr(A_IN0, 32'hFFFFFFFF);
        rd("in0_wr_ignored", A_IN0, 32'h000000C3);
        IN_PORTS[31:16] = 16'h1234;
        IOBUS_ADDR = A_IN1;
        check("in1_edge0", K_RD, 64'h0);
        check("in1_edge1", K_RD, 64'h0);
        check("in1_edge2", K_RD, 64'h1234);

        // interrupts
        wr(A_IMASK, 32'h2);
        rd("mask_rd", A_IMASK, 32'h2);
        pulse_irq(0);
        rd("pend_masked", A_ISTAT, 32'h1);
        check("intr_masked", K_INTR, 64'd0);
        pulse_irq(1);
        check("intr_set", K_INTR, 64'd1);
        rd("pend_both", A_ISTAT, 32'h3);
        wr(A_ISTAT, 32'h2);
        check("intr_w1c_lat", K_INTR, 64'd1);
        check("intr_cleared", K_INTR, 64'd0);
        rd("pend_after_w1c", A_ISTAT, 32'h1);
        IRQ_SRC[0] = 1'b1;
        tick();
        tick();
        wr(A_ISTAT, 32'h1);
        IRQ_SRC[0] = 1'b0;
        rd("set_beats_w1c", A_ISTAT, 32'h1);
        wr(A_ISTAT, 32'h1);
        rd("pend_clear0", A_ISTAT, 32'h0);

        // FIFO fill and overflow
        wr(A_TXD, 32'hFFFFFF41);
        wr(A_TXD, 32'h42);
        rd("tx_two", A_TXS, 32'h00000200);
        wr(A_TXD, 32'h43);
        wr(A_TXD, 32'h44);
        wr(A_TXD, 32'h45);
        rd("tx_full_ovf", A_TXS, 32'h00000406);
        wr(A_TXS, 32'h4);
        rd("tx_ovf_clr", A_TXS, 32'h00000402);

        // UART drain
        tx_q.push_back(8'h41);
        tx_q.push_back(8'h42);
        tx_q.push_back(8'h43);
        tx_q.push_back(8'h44);
        uart_en = 1'b1;
        for (int k = 0; k < 200 && tx_q.size() != 0; k++) tick();
        repeat (15) tick();
        rd("tx_drained", A_TXS, 32'h1);
        uart_en = 1'b0;

        // async reset mid-operation
        wr(A_TXD, 32'h51);
        wr(A_TXD, 32'h52);
        wr(A_TXD, 32'h53);
        pulse_irq(1);
        check("pre_reset_intr", K_INTR, 64'd1);
        rd("pre_reset_cnt", A_TXS, 32'h00000300);
        RESET = 1'b1;
        check("async_reset_outs", K_OUTS, 64'd0);
        rd("reset_txstat2", A_TXS, 32'h1);
        rd("reset_pend", A_ISTAT, 32'h0);
        rd("reset_mask", A_IMASK, 32'h0);
        rd("reset_out1", A_OUT1, 32'h0);
        RESET = 1'b0;
        repeat (3) tick();
        done = 1'b1;
        repeat (5) tick();
        $display("FAIL monitor_end: got running expected finished");
        $fatal(1);
    end
endmodule
